// File: rtl/imem_boot_loader.sv
// Boot loader that fills instruction memory from a little-endian byte stream and holds the core until done.
// Optional trailing checksum word is compiled in with the IMEM_LOADER_CSUM_EN macro.
`timescale 1ns/1ps
module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS    = 8192,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned WIDX_W = $clog2(DEPTH_WORDS + 1);
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef IMEM_LOADER_CSUM_EN
        ,S_CSUM = 3'd6
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [23:0]         r_shift;
    logic [1:0]          r_byte_cnt;
    logic [WIDX_W-1:0]   r_word_idx;
    logic [TO_W-1:0]     r_to_cnt;
    logic [31:0]         r_len;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]         r_sum;
`endif

    logic        w_xfer;
    logic        w_last_byte;
    logic [31:0] w_word;
    logic [31:0] w_addr;
    logic        w_timeout;
    logic        w_rx_state;
    logic        w_restart;
    state_t      w_after_last;
    logic        w_ready_nxt;
    logic        w_wr_nxt;
    logic        w_hold_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;

    // o_byte_ready mirrors "state accepts bytes", so it doubles as the handshake qualifier
    assign w_xfer      = i_byte_valid && o_byte_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_word      = {i_byte, r_shift};
    assign w_addr      = BASE_ADDR + (32'(r_word_idx) << 2);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && !w_xfer
                         && ((32'(r_to_cnt) + 32'd1) == TIMEOUT_CYCLES);
    assign w_restart   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

`ifdef IMEM_LOADER_CSUM_EN
    assign w_rx_state   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_after_last = S_CSUM;
`else
    assign w_rx_state   = (r_state == S_LEN) || (r_state == S_DATA);
    assign w_after_last = S_DONE;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state and next registered outputs
    always_comb begin
        w_next      = r_state;
        w_ready_nxt = 1'b0;
        w_wr_nxt    = 1'b0;
        w_hold_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer && w_last_byte) begin
                    if (w_word > DEPTH_WORDS) w_next = S_ERR;
                    else if (w_word == 32'd0) w_next = w_after_last;
                    else                      w_next = S_DATA;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_xfer && w_last_byte) w_next = S_WRITE;
                else if (w_timeout)        w_next = S_ERR;
            end
            S_WRITE: begin
                if ((32'(r_word_idx) + 32'd1) == r_len) w_next = w_after_last;
                else                                    w_next = S_DATA;
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (w_xfer && w_last_byte) w_next = (w_word == r_sum) ? S_DONE : S_ERR;
                else if (w_timeout)        w_next = S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase

`ifdef IMEM_LOADER_CSUM_EN
        w_ready_nxt = (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_CSUM);
`else
        w_ready_nxt = (w_next == S_LEN) || (w_next == S_DATA);
`endif
        w_wr_nxt   = (w_next == S_WRITE);
        w_done_nxt = (w_next == S_DONE);
        w_err_nxt  = (w_next == S_ERR);
        w_hold_nxt = (w_next != S_DONE);
    end

    // Registered outputs; address/data captured on the byte that completes a word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_byte_ready <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= 32'd0;
            o_wr_data    <= 32'd0;
            o_cpu_hold   <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_byte_ready <= w_ready_nxt;
            o_wr_en      <= w_wr_nxt;
            o_cpu_hold   <= w_hold_nxt;
            o_done       <= w_done_nxt;
            o_err        <= w_err_nxt;
            if (w_wr_nxt) begin
                o_wr_addr <= w_addr;
                o_wr_data <= w_word;
            end
        end
    end

    // Byte assembly, word index, length and idle-timeout counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= 24'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_to_cnt   <= '0;
            r_len      <= 32'd0;
`ifdef IMEM_LOADER_CSUM_EN
            r_sum      <= 32'd0;
`endif
        end else if (w_restart) begin
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_to_cnt   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            if (w_xfer) begin
                r_shift    <= w_word[31:8];
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_to_cnt   <= '0;
            end else if (w_rx_state) begin
                r_to_cnt   <= r_to_cnt + TO_W'(1);
            end
            if ((r_state == S_LEN) && w_xfer && w_last_byte) r_len <= w_word;
            if (r_state == S_WRITE) begin
                r_word_idx <= r_word_idx + WIDX_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
                r_sum      <= r_sum + o_wr_data;
`endif
            end
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the initial fill of the single-cycle core's instruction memory from a byte stream (UART/debug bridge) instead of a fixed hex image.
- Assembles little-endian bytes into 32-bit words and drives the instruction-memory write port with word-aligned byte addresses.
- Holds the core in stall until the load completes.
- Sits between the host byte interface, the instruction memory write port and the core's stall/reset input.

Parameters:
- DEPTH_WORDS, 8192, instruction memory capacity in words; image length above this is an error.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle pulse that begins a load session.
- i_byte_valid  input  1  host byte valid.
- i_byte  input  8  host byte data.
- o_byte_ready  output  1  loader accepts a byte this cycle (valid && ready = transfer).
- o_wr_en  output  1  instruction memory write strobe, one cycle per word.
- o_wr_addr  output  32  byte address of the word; bits [1:0] always 0.
- o_wr_data  output  32  assembled word.
- o_cpu_hold  output  1  core stall/hold; high from reset until DONE.
- o_done  output  1  load completed successfully; level.
- o_err  output  1  load aborted; level.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - State IDLE.
  - o_byte_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0.
  - o_cpu_hold=1, o_done=0, o_err=0.
  - All counters cleared.
- FSM states: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE:
  - o_byte_ready=0.
  - i_start moves to LEN and clears the byte, word and timeout counters.
- LEN:
  - o_byte_ready=1.
  - Accepts 4 bytes forming N (word count), little-endian: the first byte is bits [7:0].
  - After the 4th byte:
    - N > DEPTH_WORDS -> ERR.
    - N == 0 -> DONE (or CSUM when the option is compiled in).
    - Otherwise -> DATA.
- DATA:
  - o_byte_ready=1.
  - Accepts 4 bytes per word, little-endian.
  - On the 4th byte -> WRITE.
- WRITE:
  - Lasts exactly one cycle, with o_byte_ready=0.
  - o_wr_en=1.
  - o_wr_addr = BASE_ADDR + 4*word_idx, truncated to 32 bits.
  - o_wr_data = assembled word.
  - word_idx increments.
  - If word_idx+1 == N -> DONE (or CSUM); otherwise -> DATA.
- Write latency: o_wr_en asserts in the cycle after the 4th byte of a word is accepted. o_wr_en is 0 in every other cycle.
- DONE:
  - o_done=1, o_cpu_hold=0, o_byte_ready=0.
  - i_start re-enters LEN, sets o_done=0 and o_cpu_hold=1.
- ERR:
  - o_err=1, o_cpu_hold=1, o_byte_ready=0.
  - i_start re-enters LEN and clears o_err.
  - Words already written are not rolled back.
- Timeout:
  - In LEN/DATA, the counter increments each cycle without a transfer and clears on every transfer.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - The timeout counter is frozen in WRITE.
- i_start while in LEN/DATA/WRITE is ignored.
- Bytes presented while o_byte_ready=0 are not consumed; the host holds them.
- Byte counter wraps 3->0 within a word.
- word_idx width is clog2(DEPTH_WORDS+1).
- Reset asserted mid-load aborts immediately to IDLE with the reset values above. No partial word is written.

Optional Feature:
- Macro IMEM_LOADER_CSUM_EN.
- Defined:
  - Extra state CSUM follows the last word (or LEN when N==0).
  - CSUM accepts 4 little-endian bytes.
  - Compares them with the running 32-bit sum (mod 2^32) of all written words.
  - Match -> DONE; mismatch -> ERR.
  - The timeout applies in CSUM.
- Not defined:
  - No CSUM state and no sum register.
  - Transitions that would enter CSUM go directly to DONE.

Test Plan:
- Reset then idle 10 cycles -> o_cpu_hold=1, o_done=0, o_err=0, o_byte_ready=0, o_wr_en never high.
- i_start; bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 ->
  - one write: addr 0x0000_0000, data 0x0010_0513;
  - one write: addr 0x0000_0004, data 0x0020_0593;
  - then o_done=1, o_cpu_hold=0.
  - Under IMEM_LOADER_CSUM_EN, append checksum bytes A6 0A 30 00 (0x00300AA6) -> o_done=1 after the checksum; instead append 00 00 00 00 -> o_err=1 and o_cpu_hold stays 1.
- Header 00 00 00 00 (no options) -> no writes, o_done=1 in the cycle after the 4th byte. Header 01 20 00 00 (N=8193) -> o_err=1, no writes.
- Bursty host with random valid gaps (≤5 cycles) and TIMEOUT_CYCLES=16 -> every write matches the image and there is exactly one o_wr_en per word. Stopping after 2 bytes of a word -> o_err=1 exactly 16 cycles after the last transfer.
- Reset pulse in the middle of the 3rd word of a 4-word load -> outputs return immediately to reset values, no further o_wr_en. A subsequent full load succeeds.
- i_start pulsed during DATA -> ignored, word sequence and addresses unchanged. i_start in DONE -> o_done drops, o_cpu_hold=1, new load starts at BASE_ADDR.
